apb_gpio_irq_filt: RTL and testbench

// - Parametrised next-generation APB GPIO controller, 1..32 channels.
// - Adds per-channel input synchroniser and programmable debounce filter, five IRQ modes
//   (level-high, level-low, rising, falling, both edges), atomic set/clear of outputs and W1C IRQ status.
// - Sits on the peripheral APB bus as a zero-wait slave; INT/INT_OR go to the interrupt controller.

---
 rtl/gpio_pkg.sv | 37 +++
 rtl/gpio_in_filt.sv | 48 ++++
 rtl/apb_gpio_irq_filt.sv | 123 ++++++++++++
 tb/tb_apb_gpio_irq_filt.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared register offsets, IRQ mode encodings and the per-channel event decode for the APB GPIO block.
package gpio_pkg;

  localparam int MAX_IO = 32;

  localparam logic [7:0] ADDR_DATA_IN    = 8'h00;
  localparam logic [7:0] ADDR_DATA_OUT   = 8'h04;
  localparam logic [7:0] ADDR_OE         = 8'h08;
  localparam logic [7:0] ADDR_IRQ_EN     = 8'h0C;
  localparam logic [7:0] ADDR_IRQ_TYPE   = 8'h10;
  localparam logic [7:0] ADDR_IRQ_POL    = 8'h14;
  localparam logic [7:0] ADDR_IRQ_STATUS = 8'h18;
  localparam logic [7:0] ADDR_DEBOUNCE   = 8'h1C;
  localparam logic [7:0] ADDR_OUT_SET    = 8'h20;
  localparam logic [7:0] ADDR_OUT_CLR    = 8'h24;
  localparam logic [7:0] ADDR_IRQ_BOTH   = 8'h28;
  // Highest byte address still inside the last valid word.
  localparam logic [7:0] ADDR_LAST_BYTE  = 8'h2B;

  localparam logic IRQ_TYPE_LEVEL = 1'b0;
  localparam logic IRQ_TYPE_EDGE  = 1'b1;
  localparam logic IRQ_POL_HIGH   = 1'b0;
  localparam logic IRQ_POL_LOW    = 1'b1;

  function automatic logic irq_event(input logic typ, input logic pol, input logic both,
                                     input logic filt, input logic filt_d);
    logic ev;
    if (both)
      ev = filt ^ filt_d;
    else if (typ == IRQ_TYPE_EDGE)
      ev = (pol == IRQ_POL_LOW) ? (~filt & filt_d) : (filt & ~filt_d);
    else
      ev = (pol == IRQ_POL_LOW) ? ~filt : filt;
    return ev;
  endfunction

endpackage

// File: rtl/gpio_in_filt.sv
// One GPIO input channel: SYNC_STAGES-deep synchroniser, then a debounce filter needing DEBOUNCE
// consecutive differing samples before filt follows; filt_d is filt delayed one cycle.
module gpio_in_filt #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_W        = 8
) (
  input  logic            PCLK,
  input  logic            PRESET,
  input  logic            pad,
  input  logic [DB_W-1:0] debounce,
  input  logic            db_wr,
  output logic            filt,
  output logic            filt_d
);

  logic [SYNC_STAGES-1:0] sync;
  logic [DB_W-1:0]        cnt;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      sync   <= '0;
      cnt    <= '0;
      filt   <= 1'b0;
      filt_d <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], pad};
      filt_d <= filt;
      if (debounce == '0) begin
        filt <= s;
        cnt  <= '0;
      end else if (s == filt) begin
        cnt <= '0;
      end else if (cnt == debounce - DB_W'(1)) begin
        filt <= s;
        cnt  <= '0;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
      // A new debounce period restarts every channel's count from zero.
      if (db_wr)
        cnt <= '0;
    end
  end

endmodule

// File: rtl/apb_gpio_irq_filt.sv
// Zero-wait APB GPIO slave with filtered inputs, five IRQ modes, atomic output set/clear and W1C status.
// Writes commit on the access-phase edge; reads are combinational; INT/INT_OR are registered together.
module apb_gpio_irq_filt
  import gpio_pkg::*;
#(
  parameter int IO_NUM      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DB_W        = 8
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [7:0]        PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [IO_NUM-1:0] GPIO_IN,
  output logic [IO_NUM-1:0] GPIO_OUT,
  output logic [IO_NUM-1:0] GPIO_OE,
  output logic [IO_NUM-1:0] INT,
  output logic              INT_OR
);

  logic [IO_NUM-1:0] data_out, oe, irq_en, irq_type, irq_pol, irq_status, irq_both;
  logic [IO_NUM-1:0] filt, filt_d, evt, w1c, status_nxt, wdat;
  logic [DB_W-1:0]   debounce;
  logic [7:0]        reg_addr;
  logic [31:0]       rdata;
  logic              access, addr_ok, err, wr_ok, db_wr, int_or_q;

  assign access   = PSEL & PENABLE;
  assign reg_addr = {PADDR[7:2], 2'b00};
  assign addr_ok  = (PADDR <= ADDR_LAST_BYTE);
  assign err      = access & (~addr_ok | (PWRITE & (reg_addr == ADDR_DATA_IN)));
  assign wr_ok    = access & PWRITE & ~err;
  assign db_wr    = wr_ok & (reg_addr == ADDR_DEBOUNCE);
  assign wdat     = PWDATA[IO_NUM-1:0];

  assign PREADY   = 1'b1;
  assign PSLVERR  = err;
  assign PRDATA   = rdata;
  assign GPIO_OUT = data_out;
  assign GPIO_OE  = oe;
  assign INT      = irq_status;
  assign INT_OR   = int_or_q;

  for (genvar g = 0; g < IO_NUM; g++) begin : g_ch
    gpio_in_filt #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_W       (DB_W)
    ) u_filt (
      .PCLK    (PCLK),
      .PRESET  (PRESET),
      .pad     (GPIO_IN[g]),
      .debounce(debounce),
      .db_wr   (db_wr),
      .filt    (filt[g]),
      .filt_d  (filt_d[g])
    );
  end

  always_comb begin
    rdata = '0;
    if (access && addr_ok) begin
      case (reg_addr)
        ADDR_DATA_IN:    rdata = 32'(filt);
        ADDR_DATA_OUT:   rdata = 32'(data_out);
        ADDR_OE:         rdata = 32'(oe);
        ADDR_IRQ_EN:     rdata = 32'(irq_en);
        ADDR_IRQ_TYPE:   rdata = 32'(irq_type);
        ADDR_IRQ_POL:    rdata = 32'(irq_pol);
        ADDR_IRQ_STATUS: rdata = 32'(irq_status);
        ADDR_DEBOUNCE:   rdata = 32'(debounce);
        ADDR_IRQ_BOTH:   rdata = 32'(irq_both);
        default:         rdata = '0;
      endcase
    end
  end

  // Set beats clear, so a persisting level event survives a W1C.
  always_comb begin
    evt = '0;
    for (int i = 0; i < IO_NUM; i++)
      evt[i] = irq_event(irq_type[i], irq_pol[i], irq_both[i], filt[i], filt_d[i]);
    w1c        = (wr_ok && reg_addr == ADDR_IRQ_STATUS) ? wdat : '0;
    status_nxt = (irq_status & ~w1c) | (evt & irq_en);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      data_out   <= '0;
      oe         <= '0;
      irq_en     <= '0;
      irq_type   <= '0;
      irq_pol    <= '0;
      irq_both   <= '0;
      irq_status <= '0;
      debounce   <= '0;
      int_or_q   <= 1'b0;
    end else begin
      if (wr_ok) begin
        case (reg_addr)
          ADDR_DATA_OUT: data_out <= wdat;
          ADDR_OE:       oe       <= wdat;
          ADDR_IRQ_EN:   irq_en   <= wdat;
          ADDR_IRQ_TYPE: irq_type <= wdat;
          ADDR_IRQ_POL:  irq_pol  <= wdat;
          ADDR_IRQ_BOTH: irq_both <= wdat;
          ADDR_DEBOUNCE: debounce <= PWDATA[DB_W-1:0];
          ADDR_OUT_SET:  data_out <= data_out | wdat;
          ADDR_OUT_CLR:  data_out <= data_out & ~wdat;
          default: ;
        endcase
      end
      irq_status <= status_nxt;
      int_or_q   <= |status_nxt;
    end
  end

endmodule

// File: tb/tb_apb_gpio_irq_filt.sv
// Directed bench for apb_gpio_irq_filt with 8 channels, 2 sync stages and an 8-bit debounce register.
module tb_apb_gpio_irq_filt;

  localparam int IO_NUM = 8;

  logic              PCLK = 1'b0;
  logic              PRESET, PSEL, PENABLE, PWRITE;
  logic [7:0]        PADDR;
  logic [31:0]       PWDATA, PRDATA;
  logic              PREADY, PSLVERR, INT_OR;
  logic [IO_NUM-1:0] GPIO_IN, GPIO_OUT, GPIO_OE, INT;

  int n_cmp  = 0;
  int n_fail = 0;

  apb_gpio_irq_filt #(.IO_NUM(IO_NUM), .SYNC_STAGES(2), .DB_W(8)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .GPIO_IN(GPIO_IN), .GPIO_OUT(GPIO_OUT), .GPIO_OE(GPIO_OE), .INT(INT), .INT_OR(INT_OR)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic err);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 err = PSLVERR;
    @(posedge PCLK);
    #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic err);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 d = PRDATA; err = PSLVERR;
    @(posedge PCLK);
    #1 PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // Parks the bus in a DATA_IN access phase so PRDATA tracks the filtered inputs every cycle.
  task automatic mon_on();
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 8'h00;
  endtask

  task automatic mon_off();
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] acc;
    logic        err;

    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; GPIO_IN = '0;
    repeat (3) @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK); #1;

    check("rst_pready",   32'(PREADY),   32'h1);
    check("rst_gpio_out", 32'(GPIO_OUT), 32'h0);
    check("rst_gpio_oe",  32'(GPIO_OE),  32'h0);
    check("rst_int",      32'(INT),      32'h0);
    check("rst_int_or",   32'(INT_OR),   32'h0);
    check("idle_prdata",  PRDATA,        32'h0);
    for (int i = 0; i <= 10; i++) begin
      apb_read(8'(i * 4), rd, err);
      check($sformatf("rst_reg_%02h", i * 4), rd, 32'h0);
    end

    // Register access, upper bits and atomic set/clear
    apb_write(8'h04, 32'hFFFF_FFFF, err);
    apb_read(8'h04, rd, err);
    check("data_out_upper_zero", rd, 32'h0000_00FF);
    apb_write(8'h04, 32'h0000_00F0, err);
    apb_write(8'h20, 32'h0000_000F, err);
    apb_read(8'h04, rd, err);
    check("out_set", rd, 32'h0000_00FF);
    apb_write(8'h24, 32'h0000_0081, err);
    apb_read(8'h04, rd, err);
    check("out_clr", rd, 32'h0000_007E);
    check("gpio_out_pin", 32'(GPIO_OUT), 32'h7E);
    apb_read(8'h20, rd, err);
    check("out_set_reads_0", rd, 32'h0);
    apb_write(8'h08, 32'h0000_005A, err);
    check("gpio_oe_pin", 32'(GPIO_OE), 32'h5A);
    apb_write(8'h1C, 32'h0000_01FF, err);
    apb_read(8'h1C, rd, err);
    check("debounce_width", rd, 32'h0000_00FF);
    apb_write(8'h1C, 32'h0, err);

    // Error responses
    apb_read(8'h30, rd, err);
    check("rd_0x30_slverr", 32'(err), 32'h1);
    check("rd_0x30_data", rd, 32'h0);
    apb_write(8'h00, 32'h0000_00FF, err);
    check("wr_data_in_slverr", 32'(err), 32'h1);
    apb_read(8'h00, rd, err);
    check("data_in_unchanged", rd, 32'h0);
    check("rd_ok_no_slverr", 32'(err), 32'h0);

    // DEBOUNCE=0: bit3 rises exactly two edges after the edge that first samples it
    @(negedge PCLK);
    mon_on();
    GPIO_IN = 8'h08;
    @(negedge PCLK);
    @(negedge PCLK); #1;
    check("db0_before", PRDATA, 32'h0);
    @(negedge PCLK); #1;
    check("db0_after", PRDATA, 32'h8);
    GPIO_IN = 8'h00;
    mon_off();
    repeat (4) @(negedge PCLK);

    // DEBOUNCE=5 with rising-edge IRQ on channel 0
    apb_write(8'h1C, 32'd5, err);
    apb_write(8'h0C, 32'h1, err);
    apb_write(8'h10, 32'h1, err);
    @(negedge PCLK);
    mon_on();
    GPIO_IN = 8'h01;
    repeat (4) @(negedge PCLK);
    GPIO_IN = 8'h00;
    acc = '0;
    repeat (12) begin
      @(negedge PCLK); #1 acc = acc | PRDATA;
    end
    check("glitch_data_in", acc, 32'h0);
    check("glitch_int", 32'(INT), 32'h0);

    @(negedge PCLK);
    GPIO_IN = 8'h01;
    repeat (6) @(negedge PCLK);
    #1 check("db5_before", PRDATA, 32'h0);
    repeat (2) @(negedge PCLK);
    #1 check("db5_after", PRDATA, 32'h1);
    mon_off();
    apb_read(8'h18, rd, err);
    check("rise_status", rd, 32'h1);
    check("rise_int", 32'(INT), 32'h1);
    check("rise_int_or", 32'(INT_OR), 32'h1);
    apb_write(8'h18, 32'h1, err);
    apb_read(8'h18, rd, err);
    check("rise_w1c", rd, 32'h0);
    check("rise_w1c_int_or", 32'(INT_OR), 32'h0);

    // Level modes and IRQ_EN gating
    apb_write(8'h10, 32'h0, err);
    apb_read(8'h18, rd, err);
    check("level_high_set", rd, 32'h1);
    apb_write(8'h18, 32'h1, err);
    apb_read(8'h18, rd, err);
    check("level_w1c_set_wins", rd, 32'h1);
    apb_write(8'h14, 32'h1, err);
    apb_write(8'h18, 32'h1, err);
    apb_read(8'h18, rd, err);
    check("level_low_idle", rd, 32'h0);
    apb_write(8'h14, 32'h0, err);
    apb_write(8'h0C, 32'h0, err);
    apb_read(8'h18, rd, err);
    check("en_off_keeps_status", rd, 32'h1);
    apb_write(8'h18, 32'h1, err);
    apb_read(8'h18, rd, err);
    check("en_off_no_reset", rd, 32'h0);

    // Both-edge mode on channel 1
    apb_write(8'h28, 32'h2, err);
    apb_write(8'h0C, 32'h2, err);
    @(negedge PCLK);
    GPIO_IN = 8'h03;
    repeat (12) @(negedge PCLK);
    apb_read(8'h18, rd, err);
    check("both_rise", rd, 32'h2);
    apb_write(8'h18, 32'h2, err);
    apb_read(8'h18, rd, err);
    check("both_rise_w1c", rd, 32'h0);
    @(negedge PCLK);
    GPIO_IN = 8'h01;
    repeat (12) @(negedge PCLK);
    apb_read(8'h18, rd, err);
    check("both_fall", rd, 32'h2);
    apb_write(8'h18, 32'h2, err);
    apb_read(8'h18, rd, err);
    check("both_fall_w1c", rd, 32'h0);

    // Reset during an access-phase write discards it
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h04; PWDATA = 32'h55;
    @(negedge PCLK);
    PENABLE = 1'b1; PRESET = 1'b1;
    @(posedge PCLK);
    #1 PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    check("midrst_gpio_out", 32'(GPIO_OUT), 32'h0);
    check("midrst_gpio_oe", 32'(GPIO_OE), 32'h0);
    apb_read(8'h1C, rd, err);
    check("midrst_debounce", rd, 32'h0);
    apb_read(8'h28, rd, err);
    check("midrst_irq_both", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
